// File: rtl/mem_pkg.sv
// Shared types, sizes and the doubleword range check for the data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DWORD_BYTES = 8;
  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned DATA_W      = 64;

  // True when all eight bytes addr..addr+7 lie below depth. The sum is formed
  // one bit wider than the address so addresses near 2^64 cannot wrap back
  // into range.
  function automatic logic dword_in_range(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] depth);
    logic [ADDR_W:0] last_byte;
    last_byte = {1'b0, addr} + (ADDR_W+1)'(DWORD_BYTES - 1);
    return (last_byte < {1'b0, depth});
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressable storage with one 8-byte little-endian port:
// clocked write, combinational read. Contents are never reset.
import mem_pkg::*;

module mem_byte_array #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0] mem_q [DEPTH_BYTES];

  // Write byte i of the doubleword to address addr_i+i (lowest byte first).
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < DWORD_BYTES; i++) begin
        mem_q[addr_i + AW'(i)] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Assemble the read doubleword with the same little-endian byte order.
  always_comb begin
    rdata_o = {DATA_W{1'b0}};
    for (int i = 0; i < DWORD_BYTES; i++) begin
      rdata_o[8*i +: 8] = mem_q[addr_i + AW'(i)];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the data-memory interface: accepts one doubleword
// load/store at a time, waits LATENCY cycles, then returns a registered
// response under a valid/ready handshake.
import mem_pkg::*;

module data_mem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  state_e            state_q;
  logic [3:0]        count_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  logic              access_err_s;
  logic              access_now_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_rdata_s;

  // Classify the latched request and decide whether storage is written this edge.
  // Reset gates the write so an abandoned store never commits.
  always_comb begin
    access_err_s = (addr_q[2:0] != 3'd0) ||
                   !dword_in_range(addr_q, ADDR_W'(DEPTH_BYTES));
    access_now_s = (state_q == BUSY) && (count_q == 4'd0);
    mem_we_s     = access_now_s && wr_q && !access_err_s && !reset;
  end

  mem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (AW)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (mem_we_s),
    .addr_i  (addr_q[AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata_s)
  );

  // Request/response FSM with wait-state counter and registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {DATA_W{1'b0}};
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            wr_q        <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            count_q     <= 4'(LATENCY);
            req_ready_q <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
          end else begin
            resp_err_q   <= access_err_s;
            resp_rdata_q <= (wr_q || access_err_s) ? {DATA_W{1'b0}} : mem_rdata_s;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {DATA_W{1'b0}};
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b0;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= {DATA_W{1'b0}};
          resp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (LATENCY 2, 3 and 0) sharing clock and reset.
module tb_data_mem_responder;

  logic        CLK;
  logic        reset;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [63:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [63:0] resp_rdata [3];
  logic        resp_err   [3];

  int total;
  int bad;

  data_mem_responder #(.DEPTH_BYTES(1024), .LATENCY(2)) dut_l2 (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  data_mem_responder #(.DEPTH_BYTES(1024), .LATENCY(3)) dut_l3 (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  data_mem_responder #(.DEPTH_BYTES(1024), .LATENCY(0)) dut_l0 (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(i) << 8) | 64'(i);
  endfunction

  // One complete transaction with resp_ready held high. lat = edges from
  // the accept edge until resp_valid is seen high.
  task automatic run_txn(input int k, input logic wr, input logic [63:0] a,
                         input logic [63:0] wd, output logic [63:0] rd,
                         output logic er, output int lat);
    int n;
    @(negedge CLK);
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("ready_wait", 64'(n < 50), 64'd1);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    @(posedge CLK); #1;
    req_valid[k] = 1'b0;
    req_write[k] = ~wr;
    req_addr[k]  = ~a;
    req_wdata[k] = ~wd;
    lat = 0;
    while (resp_valid[k] !== 1'b1 && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    rd = resp_rdata[k];
    er = resp_err[k];
    @(posedge CLK); #1;
    check("done_valid", 64'(resp_valid[k]), 64'd0);
    check("done_ready", 64'(req_ready[k]), 64'd1);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          n;
    int          issued;
    int          got;
    int          cyc;
    int          last_acc;

    total = 0;
    bad   = 0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 1'b0;
      req_write[k]  = 1'b0;
      req_addr[k]   = 64'd0;
      req_wdata[k]  = 64'd0;
      resp_ready[k] = 1'b1;
    end

    // Reset with a store request already presented on the LATENCY=2 port.
    reset        = 1'b1;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 64'h08;
    req_wdata[0] = 64'h1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      check("rst_outputs", {60'd0, req_ready[0], resp_valid[0], resp_err[0], |resp_rdata[0]}, 64'd0);
    end
    reset = 1'b0;
    @(posedge CLK); #1;
    check("rst_first_ready", 64'(req_ready[0]), 64'd1);
    @(posedge CLK); #1;
    check("rst_accept", 64'(req_ready[0]), 64'd0);
    req_valid[0] = 1'b0;
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    check("rst_store_lat", 64'(n), 64'd3);
    check("rst_store_err", 64'(resp_err[0]), 64'd0);
    @(posedge CLK); #1;
    check("rst_store_done", 64'(resp_valid[0]), 64'd0);

    // Store then load at 0x10.
    run_txn(0, 1'b1, 64'h10, 64'h0123456789ABCDEF, rd, er, lat);
    check("st_lat", 64'(lat), 64'd3);
    check("st_err", 64'(er), 64'd0);
    check("st_rdata", rd, 64'd0);
    run_txn(0, 1'b0, 64'h10, 64'd0, rd, er, lat);
    check("ld_lat", 64'(lat), 64'd3);
    check("ld_err", 64'(er), 64'd0);
    check("ld_rdata", rd, 64'h0123456789ABCDEF);

    // Error cases and range boundaries.
    run_txn(0, 1'b1, 64'h13, 64'hDEAD_BEEF, rd, er, lat);
    check("mis_st_err", 64'(er), 64'd1);
    check("mis_st_rdata", rd, 64'd0);
    run_txn(0, 1'b0, 64'd1020, 64'd0, rd, er, lat);
    check("oor_ld_err", 64'(er), 64'd1);
    check("oor_ld_rdata", rd, 64'd0);
    run_txn(0, 1'b1, 64'd1016, 64'h7777_6666_5555_4444, rd, er, lat);
    check("top_st_err", 64'(er), 64'd0);
    run_txn(0, 1'b0, 64'd1016, 64'd0, rd, er, lat);
    check("top_ld_err", 64'(er), 64'd0);
    check("top_ld_rdata", rd, 64'h7777_6666_5555_4444);
    run_txn(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, rd, er, lat);
    check("wrap_ld_err", 64'(er), 64'd1);
    check("wrap_ld_rdata", rd, 64'd0);
    run_txn(0, 1'b0, 64'h10, 64'd0, rd, er, lat);
    check("after_err_ld", rd, 64'h0123456789ABCDEF);

    // A doubleword store of 0xAA overwrites all eight bytes.
    run_txn(0, 1'b1, 64'h10, 64'hAA, rd, er, lat);
    run_txn(0, 1'b0, 64'h10, 64'd0, rd, er, lat);
    check("aa_ld_rdata", rd, 64'h0000_0000_0000_00AA);

    // Back-pressure: hold resp_ready low for 5 cycles.
    resp_ready[0] = 1'b0;
    @(negedge CLK);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 64'h08;
    @(posedge CLK); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    check("bp_lat", 64'(n), 64'd3);
    for (int c = 0; c < 5; c++) begin
      req_valid[0] = 1'b1;
      @(posedge CLK); #1;
      check("bp_valid_hold", 64'(resp_valid[0]), 64'd1);
      check("bp_rdata_hold", resp_rdata[0], 64'h1111);
      check("bp_ready_low", 64'(req_ready[0]), 64'd0);
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge CLK); #1;
    check("bp_release_valid", 64'(resp_valid[0]), 64'd0);
    check("bp_release_ready", 64'(req_ready[0]), 64'd1);

    // LATENCY=3: a store abandoned by reset must not commit.
    run_txn(1, 1'b1, 64'h20, 64'h5555, rd, er, lat);
    check("l3_st_lat", 64'(lat), 64'd4);
    @(negedge CLK);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 64'h20;
    req_wdata[1] = 64'hFFFF;
    @(posedge CLK); #1;
    req_valid[1] = 1'b0;
    check("l3_abort_accept", 64'(req_ready[1]), 64'd0);
    @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (resp_valid[1] === 1'b1) n++;
    end
    check("l3_no_resp", 64'(n), 64'd0);
    run_txn(1, 1'b0, 64'h20, 64'd0, rd, er, lat);
    check("l3_old_value", rd, 64'h5555);

    // LATENCY=0: preload ten doublewords, then back-to-back loads.
    for (int i = 0; i < 10; i++) begin
      run_txn(2, 1'b1, 64'(i * 8), pat(i), rd, er, lat);
      if (i == 0) check("l0_lat", 64'(lat), 64'd1);
    end
    issued   = 0;
    got      = 0;
    cyc      = 0;
    last_acc = 0;
    while (got < 10 && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      if (resp_valid[2] === 1'b1) begin
        check("b2b_data", resp_rdata[2], pat(got));
        got++;
      end
      if (req_ready[2] === 1'b1 && issued < 10) begin
        if (issued > 0) check("b2b_spacing", 64'(cyc - last_acc), 64'd3);
        last_acc     = cyc;
        req_valid[2] = 1'b1;
        req_write[2] = 1'b0;
        req_addr[2]  = 64'(issued * 8);
        issued++;
      end else if (issued >= 10) begin
        req_valid[2] = 1'b0;
      end
    end
    req_valid[2] = 1'b0;
    check("b2b_issued", 64'(issued), 64'd10);
    check("b2b_got", 64'(got), 64'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
